regfile_scoreboard: RTL and testbench

- Architectural integer register file plus busy-bit scoreboard. It is the write-side counterpart of the ID stage.
- ID reads rs1/rs2 operands and reserves rd on issue. The writeback path writes rd and releases the reservation.
- Generates the read-after-write / write-after-write stall that ID consumes on its stall input.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_array.sv | 33 +++
 rtl/regfile_scoreboard.sv | 89 ++++++++
 tb/tb_regfile_scoreboard.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and types: register width, address width, x0 address.
package riscv_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// ID/writeback bundle between the decode stage and the register file scoreboard.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned AW   = riscv_pkg::AW
);
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic            rs1_use_i;
  logic            rs2_use_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            issue_wr_i;
  logic            wb_valid_i;
  logic [AW-1:0]   wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            flush_i;
  logic            stall_o;
  logic [AW:0]     busy_cnt_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
    output issue_valid_i, issue_rd_i, issue_wr_i,
    output wb_valid_i, wb_rd_i, wb_data_i, flush_i,
    input  rs1_data_o, rs2_data_o, stall_o, busy_cnt_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
    input  issue_valid_i, issue_rd_i, issue_wr_i,
    input  wb_valid_i, wb_rd_i, wb_data_i, flush_i,
    output rs1_data_o, rs2_data_o, stall_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_array.sv
// NREGS x XLEN register storage: one write port, two combinational read ports, x0 hardwired to 0.
module regfile_array
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREGS = riscv_pkg::NREGS,
  parameter int unsigned AW    = riscv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with busy-bit scoreboard, write bypass and RAW/WAW stall generation.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREGS = riscv_pkg::NREGS,
  parameter int unsigned AW    = riscv_pkg::AW
) (
  input logic clk,
  input logic rst_n,
  regfile_scoreboard_if.slave bus
);
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_n;
  logic [NREGS-1:0] wb_hot;
  logic [NREGS-1:0] eff_busy;
  logic [AW:0]      busy_cnt;
  logic [XLEN-1:0]  arr_rd1;
  logic [XLEN-1:0]  arr_rd2;
  logic             wb_en;
  logic             haz1, haz2, haz3;
  logic             stall;
  logic             issue_ok;
  logic             set_en;
  logic             clr_en;

  regfile_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (bus.wb_rd_i),
    .wdata  (bus.wb_data_i),
    .raddr1 (bus.rs1_addr_i),
    .raddr2 (bus.rs2_addr_i),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  always_comb begin
    wb_en  = bus.wb_valid_i && (bus.wb_rd_i != REG_ZERO);
    wb_hot = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (wb_en && bus.wb_rd_i == AW'(i)) wb_hot[i] = 1'b1;
    end
    // A writeback releases its register in the same cycle it arrives.
    eff_busy = busy & ~wb_hot;

    haz1     = bus.rs1_use_i  && eff_busy[bus.rs1_addr_i];
    haz2     = bus.rs2_use_i  && eff_busy[bus.rs2_addr_i];
    haz3     = bus.issue_wr_i && eff_busy[bus.issue_rd_i];
    stall    = bus.issue_valid_i && !bus.flush_i && (haz1 || haz2 || haz3);
    issue_ok = bus.issue_valid_i && !stall && !bus.flush_i;
    set_en   = issue_ok && bus.issue_wr_i && (bus.issue_rd_i != REG_ZERO);
    clr_en   = |(busy & wb_hot);

    // Set after clear so a same-edge issue to the retiring rd keeps it reserved.
    busy_n = eff_busy;
    if (set_en) busy_n[bus.issue_rd_i] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (bus.flush_i) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_n;
      unique case ({set_en, clr_en})
        2'b10:   busy_cnt <= busy_cnt + 1'b1;
        2'b01:   busy_cnt <= busy_cnt - 1'b1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  always_comb begin
    bus.rs1_data_o = (wb_en && bus.wb_rd_i == bus.rs1_addr_i) ? bus.wb_data_i : arr_rd1;
    bus.rs2_data_o = (wb_en && bus.wb_rd_i == bus.rs2_addr_i) ? bus.wb_data_i : arr_rd2;
    bus.stall_o    = stall;
    bus.busy_cnt_o = busy_cnt;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios then random traffic vs a reference model.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32), .AW(5)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use1, use2;
    logic        iv;
    logic [4:0]  rd;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        flush;
  } stim_t;

  typedef struct {
    logic [31:0] d1, d2;
    logic        stall;
    logic [5:0]  cnt;
  } exp_t;

  // Reference state: plain architectural view of registers and reservations.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  exp_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;
  stim_t       prev;
  bit          prev_valid = 0;
  bit          prev_rst = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rs1: '0, rs2: '0, use1: 0, use2: 0, iv: 0, rd: '0, wr: 0,
          wbv: 0, wbrd: '0, wbdata: '0, flush: 0};
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
  endfunction

  function automatic bit m_pending(input logic [4:0] r, input stim_t s);
    if (r == 0) return 0;
    if (s.wbv && s.wbrd == r) return 0;
    return m_busy[r];
  endfunction

  function automatic bit m_stall(input stim_t s);
    bit raw;
    raw = (s.use1 && m_pending(s.rs1, s)) || (s.use2 && m_pending(s.rs2, s)) ||
          (s.wr && m_pending(s.rd, s));
    return s.iv && !s.flush && raw;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input stim_t s);
    if (a == 0) return '0;
    if (s.wbv && s.wbrd == a) return s.wbdata;
    return m_regs[a];
  endfunction

  function automatic exp_t predict(input stim_t s, input bit in_rst);
    exp_t e;
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    if (in_rst) begin
      e = '{d1: '0, d2: '0, stall: 1'b0, cnt: '0};
    end else begin
      e.d1    = m_read(s.rs1, s);
      e.d2    = m_read(s.rs2, s);
      e.stall = m_stall(s);
      e.cnt   = 6'(n);
    end
    return e;
  endfunction

  function automatic void model_edge(input stim_t s);
    bit accepted;
    accepted = s.iv && !s.flush && !m_stall(s);
    if (s.wbv && s.wbrd != 0) begin
      m_regs[s.wbrd] = s.wbdata;
      m_busy[s.wbrd] = 0;
    end
    if (accepted && s.wr && s.rd != 0) m_busy[s.rd] = 1;
    if (s.flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endfunction

  task automatic step(input stim_t s, input bit rst_level);
    @(posedge clk);
    if (prev_valid && !prev_rst) model_edge(prev);
    #1;
    bus.rs1_addr_i    = s.rs1;
    bus.rs2_addr_i    = s.rs2;
    bus.rs1_use_i     = s.use1;
    bus.rs2_use_i     = s.use2;
    bus.issue_valid_i = s.iv;
    bus.issue_rd_i    = s.rd;
    bus.issue_wr_i    = s.wr;
    bus.wb_valid_i    = s.wbv;
    bus.wb_rd_i       = s.wbrd;
    bus.wb_data_i     = s.wbdata;
    bus.flush_i       = s.flush;
    rst_n             = rst_level;
    if (!rst_level) model_reset();
    exp_q.push_back(predict(s, !rst_level));
    prev       = s;
    prev_rst   = !rst_level;
    prev_valid = 1;
  endtask

  task automatic issue(input logic [4:0] rd);
    stim_t s = idle();
    s.iv = 1; s.wr = 1; s.rd = rd;
    step(s, 1);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ($isunknown({bus.rs1_data_o, bus.rs2_data_o, bus.stall_o, bus.busy_cnt_o})) begin
        errors++;
        $display("FAIL no_x: got rs1=%h rs2=%h stall=%b cnt=%h, required no X",
                 bus.rs1_data_o, bus.rs2_data_o, bus.stall_o, bus.busy_cnt_o);
      end
      checks++;
      if (bus.rs1_data_o !== e.d1) begin
        errors++;
        $display("FAIL rs1_data @%0t: got %h, required %h", $time, bus.rs1_data_o, e.d1);
      end
      checks++;
      if (bus.rs2_data_o !== e.d2) begin
        errors++;
        $display("FAIL rs2_data @%0t: got %h, required %h", $time, bus.rs2_data_o, e.d2);
      end
      checks++;
      if (bus.stall_o !== e.stall) begin
        errors++;
        $display("FAIL stall @%0t: got %b, required %b", $time, bus.stall_o, e.stall);
      end
      checks++;
      if (bus.busy_cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL busy_cnt @%0t: got %0d, required %0d", $time, bus.busy_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    model_reset();
    bus.rs1_addr_i = '0; bus.rs2_addr_i = '0; bus.rs1_use_i = 0; bus.rs2_use_i = 0;
    bus.issue_valid_i = 0; bus.issue_rd_i = '0; bus.issue_wr_i = 0;
    bus.wb_valid_i = 0; bus.wb_rd_i = '0; bus.wb_data_i = '0; bus.flush_i = 0;

    // Reset, then read every address.
    step(idle(), 0);
    step(idle(), 0);
    for (int a = 0; a < 32; a++) begin
      s = idle(); s.rs1 = 5'(a); s.rs2 = 5'(31 - a);
      step(s, 1);
    end

    // RAW on x5 resolved by same-cycle writeback bypass.
    issue(5'd5);
    s = idle(); s.iv = 1; s.rs1 = 5'd5; s.use1 = 1;
    step(s, 1);
    step(s, 1);
    s.wbv = 1; s.wbrd = 5'd5; s.wbdata = 32'hDEADBEEF;
    step(s, 1);
    s = idle(); s.rs1 = 5'd5;
    step(s, 1);

    // x0: writes dropped, never reserved, never stalls.
    s = idle(); s.wbv = 1; s.wbrd = 5'd0; s.wbdata = 32'h12345678;
    s.iv = 1; s.wr = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.use1 = 1;
    step(s, 1);
    s = idle(); s.iv = 1; s.rs1 = 5'd0; s.use1 = 1;
    step(s, 1);

    // Same-edge issue and writeback to x7: reservation survives, data lands.
    issue(5'd7);
    s = idle(); s.iv = 1; s.wr = 1; s.rd = 5'd7;
    s.wbv = 1; s.wbrd = 5'd7; s.wbdata = 32'hA5A5A5A5;
    step(s, 1);
    s = idle(); s.rs1 = 5'd7;
    step(s, 1);
    s = idle(); s.wbv = 1; s.wbrd = 5'd7; s.wbdata = 32'h0000_0077;
    step(s, 1);

    // Flush with a concurrent issue: nothing accepted, all reservations cleared.
    issue(5'd1); issue(5'd2); issue(5'd3);
    s = idle(); s.iv = 1; s.wr = 1; s.rd = 5'd4; s.flush = 1;
    step(s, 1);
    s = idle(); s.iv = 1; s.rs1 = 5'd1; s.use1 = 1;
    step(s, 1);
    step(idle(), 1);

    // Reset mid-run with three registers reserved.
    issue(5'd1); issue(5'd2); issue(5'd3);
    s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd7;
    step(s, 0);
    step(s, 1);

    // Random traffic; writebacks biased toward currently reserved registers.
    for (int c = 0; c < 10000; c++) begin
      s.rs1    = 5'($urandom_range(0, 31));
      s.rs2    = 5'($urandom_range(0, 31));
      s.use1   = 1'($urandom_range(0, 1));
      s.use2   = 1'($urandom_range(0, 1));
      s.iv     = ($urandom_range(0, 9) < 7);
      s.rd     = 5'($urandom_range(0, 31));
      s.wr     = ($urandom_range(0, 9) < 8);
      s.wbv    = ($urandom_range(0, 9) < 5);
      s.wbrd   = 5'($urandom_range(0, 31));
      s.wbdata = $urandom();
      s.flush  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 6) begin
        for (int k = 0; k < 8; k++) begin
          int r = $urandom_range(1, 31);
          if (m_busy[r]) begin
            s.wbrd = 5'(r);
            break;
          end
        end
      end
      step(s, 1);
    end
    step(idle(), 1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
